gf180mcu_fd_sc_mcu9t5v0__bufz_bank: RTL

GF180MCU_FD_SC_MCU9T5V0__BUFZ_BANK -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__bufz_bank

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_pkg.sv | 29 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_slice.sv | 12 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_bank.sv | 97 +++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_pkg.sv
// Shared types and helpers for the tristate bus bank: FSM states and the
// round-robin winner search used at every arbitration point.
package gf180mcu_fd_sc_mcu9t5v0__bufz_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GUARD} bufz_state_e;

  localparam int MAX_CH = 16;

  // First requester strictly after 'last', wrapping over n channels; the
  // previous owner is therefore always searched last.
  function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0] last,
                                         input int n);
    logic [3:0] w;
    logic found;
    int c;
    w = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      c = (int'(last) + k) % n;
      if (k <= n && !found && req[c[3:0]]) begin
        w = 4'(c);
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_slice.sv
// WIDTH-wide tristate driver: Z follows I while EN, otherwise floats.
module gf180mcu_fd_sc_mcu9t5v0__bufz_slice #(
  parameter int WIDTH = 8
) (
  input  logic             EN,
  input  logic [WIDTH-1:0] I,
  output wire  [WIDTH-1:0] Z
);

  assign Z = EN ? I : {WIDTH{1'bz}};

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_bank.sv
// Round-robin owner arbitration for a shared tristate bus with guard
// cycles between owners and an optional hold limit under contention.
module gf180mcu_fd_sc_mcu9t5v0__bufz_bank
  import gf180mcu_fd_sc_mcu9t5v0__bufz_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int TURN     = 1,
  parameter int MAXHOLD  = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       REQ,
  input  logic [CHANNELS*WIDTH-1:0] I,
  output logic [CHANNELS-1:0]       GNT,
  output logic                      OE,
  output wire  [WIDTH-1:0]          Z,
  inout  wire                       VDD,
  inout  wire                       VSS
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  bufz_state_e      state;
  logic [IW-1:0]    owner, last_owner, win;
  logic [7:0]       hold, hold_inc;
  logic [2:0]       guard_cnt;
  logic [MAX_CH-1:0] req_x;
  logic             any_req, own_req, others, keep, release_now, last_guard, do_arb;
  logic [WIDTH-1:0] dsel;

  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  always_comb begin
    req_x = '0;
    req_x[CHANNELS-1:0] = REQ;
  end

  assign win         = IW'(rr_pick(req_x, 4'(last_owner), CHANNELS));
  assign any_req     = |REQ;
  assign own_req     = |(REQ & GNT);
  assign others      = |(REQ & ~GNT);
  assign hold_inc    = (hold == 8'hFF) ? hold : hold + 8'd1;
  // hold_inc counts DRIVE cycles including the current one
  assign keep        = own_req && ((MAXHOLD == 0) || (int'(hold_inc) < MAXHOLD) || !others);
  assign release_now = (state == ST_DRIVE) && !keep;
  assign last_guard  = (state == ST_GUARD) && (int'(guard_cnt) == TURN - 1);
  assign do_arb      = (state == ST_IDLE) || last_guard || (release_now && TURN == 0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= IW'(CHANNELS - 1);
      hold       <= '0;
      guard_cnt  <= '0;
      GNT        <= '0;
      OE         <= 1'b0;
    end else if (do_arb) begin
      if (any_req) begin
        state      <= ST_DRIVE;
        owner      <= win;
        last_owner <= win;
        hold       <= '0;
        GNT        <= {{(CHANNELS-1){1'b0}}, 1'b1} << win;
        OE         <= 1'b1;
      end else begin
        state <= ST_IDLE;
        GNT   <= '0;
        OE    <= 1'b0;
      end
    end else if (release_now) begin
      state     <= ST_GUARD;
      guard_cnt <= '0;
      GNT       <= '0;
      OE        <= 1'b0;
    end else if (state == ST_GUARD) begin
      guard_cnt <= guard_cnt + 3'd1;
    end else if (state == ST_DRIVE) begin
      hold <= hold_inc;
    end
  end

  always_comb begin
    dsel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (owner == IW'(k)) dsel = I[k*WIDTH +: WIDTH];
  end

  gf180mcu_fd_sc_mcu9t5v0__bufz_slice #(.WIDTH(WIDTH)) u_slice (
    .EN (OE),
    .I  (dsel),
    .Z  (Z)
  );

endmodule
